// File: rtl/alu_multicycle_if.sv
// -----------------------------------------------------------------------------
// alu_multicycle_if
//
// Bundles the operand/request channel and the result/condition-code channel of
// alu_multicycle.
//
// Handshake rules (both channels):
//   - A transfer happens on a rising clock edge where valid and ready are both
//     high.
//   - The producer holds valid, and the payload, stable until that transfer.
//   - The ready signal may be high without a pending valid.
//
// Signals:
//   in_valid   request presented (master -> slave)
//   in_ready   slave can accept a new operation
//   op         0=add, 1=sub, 2=and, 3=xor
//   a, b       operands, two's complement
//   out_valid  result and condition codes valid (slave -> master)
//   out_ready  master accepts the result
//   result     operation result
//   zf, sf, of Y86-64 condition codes
//
// Modports:
//   master  upstream/downstream side (execute-stage latches, CC register)
//   slave   the ALU itself
// -----------------------------------------------------------------------------
interface alu_multicycle_if #(
  parameter int WIDTH = 64
) ();

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zf;
  logic             sf;
  logic             of;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zf, sf, of
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zf, sf, of
  );

endinterface

// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
//
// Multi-cycle add/sub/and/xor ALU producing Y86-64 condition codes. Operands are
// processed CHUNK bits per clock; a registered carry links consecutive chunks,
// so only a CHUNK-bit adder is needed.
//
// Parameters:
//   WIDTH   operand/result width (default 64)
//   CHUNK   bits processed per cycle (default 16); WIDTH must be a multiple
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          alu_multicycle_if slave modport (request + result channels)
//   dbg_state_o  current FSM state (0=IDLE, 1=BUSY, 2=DONE)
//
// Operation:
//   IDLE  accepts a request, latches operands (B inverted and carry-in set to 1
//         for sub, so sub = a + ~b + 1).
//   BUSY  one chunk per edge, least significant chunk first. The operand
//         registers shift right by CHUNK each edge so the active slice is
//         always the low CHUNK bits; the slice result enters the working
//         register from the top.
//   DONE  presents result and flags until out_ready.
//   Result/flag registers are only written on the edge that enters DONE, so
//   they hold their previous value through IDLE and BUSY.
// -----------------------------------------------------------------------------
module alu_multicycle #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_multicycle_if.slave   bus,
  output logic [1:0]        dbg_state_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("alu_multicycle: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;        // already inverted for sub
  logic [1:0]       op_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] work_q;     // partial result, filled from the top
  logic [WIDTH-1:0] result_q;
  logic             zf_q;
  logic             sf_q;
  logic             of_q;
  logic             in_ready_q;
  logic             out_valid_q;

  // ---------------------------------------------------------------------------
  // Chunk datapath
  // ---------------------------------------------------------------------------
  logic [CHUNK-1:0]       a_sl;
  logic [CHUNK-1:0]       b_sl;
  logic [CHUNK:0]         sum_ext;
  logic [CHUNK-1:0]       slice_res;
  logic                   is_arith;
  logic                   carry_out;
  logic                   carry_into_msb;
  logic [WIDTH+CHUNK-1:0] shift_cat;
  logic [WIDTH-1:0]       work_d;
  logic [WIDTH-1:0]       a_d;
  logic [WIDTH-1:0]       b_d;
  logic                   carry_d;
  logic                   zf_d;
  logic                   sf_d;
  logic                   of_d;
  logic                   is_last;

  always_comb begin
    a_sl      = a_q[CHUNK-1:0];
    b_sl      = b_q[CHUNK-1:0];
    sum_ext   = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
    is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);

    slice_res = sum_ext[CHUNK-1:0];
    case (op_q)
      OP_AND:  slice_res = a_sl & b_sl;
      OP_XOR:  slice_res = a_sl ^ b_sl;
      default: slice_res = sum_ext[CHUNK-1:0];
    endcase

    carry_out = sum_ext[CHUNK];
    // Sum bit = a ^ b ^ carry-in, so the carry entering the slice MSB can be
    // recovered without a separate (CHUNK-1)-bit adder.
    carry_into_msb = sum_ext[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];
    carry_d   = is_arith & carry_out;

    // Concatenate then take the upper WIDTH bits: works even when CHUNK==WIDTH.
    shift_cat = {slice_res, work_q};
    work_d    = shift_cat[WIDTH+CHUNK-1:CHUNK];
    a_d       = a_q >> CHUNK;
    b_d       = b_q >> CHUNK;

    is_last   = (cnt_q == CNT_LAST);

    // Flags are only meaningful on the last chunk, where work_d is complete
    // and the slice MSB is the result MSB.
    zf_d      = ~|work_d;
    sf_d      = work_d[WIDTH-1];
    of_d      = is_arith & (carry_into_msb ^ carry_out);
  end

  // ---------------------------------------------------------------------------
  // FSM and registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      work_q      <= '0;
      result_q    <= '0;
      zf_q        <= 1'b0;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
            carry_q    <= (bus.op == OP_SUB);
            op_q       <= bus.op;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_BUSY;
          end
        end

        S_BUSY: begin
          a_q     <= a_d;
          b_q     <= b_d;
          work_q  <= work_d;
          carry_q <= carry_d;
          if (is_last) begin
            result_q    <= work_d;
            zf_q        <= zf_d;
            sf_q        <= sf_d;
            of_q        <= of_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_DONE: begin
          // in_valid is deliberately ignored here; upstream keeps holding it.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zf        = zf_q;
  assign bus.sf        = sf_q;
  assign bus.of        = of_q;
  assign dbg_state_o   = state_q;

endmodule
